// File: rtl/spi_register_slave_if.sv
// 3-wire SPI pin bundle between the configuration controller and a register responder.
interface spi_register_slave_if;
  logic sclk;
  logic csb;
  logic sdio_in;
  logic sdio_out;
  logic sdio_oe;

  modport master (output sclk, csb, sdio_in, input sdio_out, sdio_oe);
  modport slave  (input sclk, csb, sdio_in, output sdio_out, sdio_oe);
endinterface

// File: rtl/spi_register_slave.sv
// SPI register responder: oversamples sclk/csb/sdio in sys_clk, decodes a 16-bit
// instruction and services byte writes/reads against a small register file.
module spi_register_slave #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                       sys_clk,
  input  logic                       reset_n,
  spi_register_slave_if.slave        spi,
  output logic                       wr_stb,
  output logic [12:0]                wr_addr,
  output logic [7:0]                 wr_data,
  output logic                       busy
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_INSTR = 2'd1;
  localparam logic [1:0] ST_WDATA = 2'd2;
  localparam logic [1:0] ST_RDATA = 2'd3;

  logic [1:0]  sclk_sync_q, sclk_sync_d, csb_sync_q, csb_sync_d, sdio_sync_q, sdio_sync_d;
  logic        sclk_prev_q, sclk_prev_d, csb_prev_q, csb_prev_d;
  logic        rise_q, rise_d, fall_q, fall_d;
  logic [1:0]  state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [14:0] instr_sh_q, instr_sh_d;
  logic [6:0]  dat_sh_q, dat_sh_d;
  logic [7:0]  rd_sh_q, rd_sh_d;
  logic [1:0]  wcnt_q, wcnt_d, byte_cnt_q, byte_cnt_d;
  logic        done_q, done_d;
  logic [12:0] addr_q, addr_d;
  logic        sdio_out_q, sdio_out_d, sdio_oe_q, sdio_oe_d;
  logic        wr_stb_q, wr_stb_d;
  logic [12:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic [7:0]            mem_q [DEPTH];
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_wa;
  logic [7:0]            mem_wd;

  logic        byte_end;
  logic        sdio_bit;
  logic [15:0] instr_next;
  logic [7:0]  wbyte;
  logic [12:0] rd_a;
  logic [7:0]  rd_byte;

  assign sdio_bit   = sdio_sync_q[1];
  assign instr_next = {instr_sh_q, sdio_bit};
  assign wbyte      = {dat_sh_q, sdio_bit};
  // One lookup port: the first byte's address comes from the instruction, later ones from addr-1.
  assign rd_a       = (state_q == ST_INSTR) ? instr_next[12:0] : addr_q - 13'd1;
  assign rd_byte    = ((rd_a >> DEPTH_LOG2) == 13'd0) ? mem_q[rd_a[DEPTH_LOG2-1:0]] : 8'h00;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[0], spi.sclk};
    csb_sync_d  = {csb_sync_q[0], spi.csb};
    sdio_sync_d = {sdio_sync_q[0], spi.sdio_in};
    sclk_prev_d = sclk_sync_q[1];
    csb_prev_d  = csb_sync_q[1];
    rise_d      = sclk_sync_q[1] & ~sclk_prev_q;
    fall_d      = ~sclk_sync_q[1] & sclk_prev_q;

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    instr_sh_d = instr_sh_q;
    dat_sh_d   = dat_sh_q;
    rd_sh_d    = rd_sh_q;
    wcnt_d     = wcnt_q;
    byte_cnt_d = byte_cnt_q;
    done_d     = done_q;
    addr_d     = addr_q;
    sdio_out_d = sdio_out_q;
    sdio_oe_d  = sdio_oe_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;
    mem_wa     = addr_q[DEPTH_LOG2-1:0];
    mem_wd     = wbyte;
    byte_end   = 1'b0;

    // csb high overrides any pending edge, so a coincident sclk rise is dropped.
    if (csb_sync_q[1]) begin
      state_d    = ST_IDLE;
      sdio_oe_d  = 1'b0;
      sdio_out_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (csb_prev_q) begin
            state_d   = ST_INSTR;
            bit_cnt_d = '0;
          end
        end
        ST_INSTR: begin
          if (rise_q) begin
            instr_sh_d = instr_next[14:0];
            bit_cnt_d  = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              bit_cnt_d  = '0;
              wcnt_d     = instr_next[14:13];
              addr_d     = instr_next[12:0];
              byte_cnt_d = '0;
              done_d     = 1'b0;
              if (instr_next[15]) begin
                state_d = ST_RDATA;
                rd_sh_d = rd_byte;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_WDATA: begin
          if (rise_q) begin
            dat_sh_d  = wbyte[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              byte_end  = 1'b1;
              if (!done_q) begin
                wr_stb_d  = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = wbyte;
                mem_we    = ((addr_q >> DEPTH_LOG2) == 13'd0);
              end
            end
          end
        end
        default: begin
          if (fall_q) begin
            if (!done_q) begin
              sdio_out_d = rd_sh_q[7];
              rd_sh_d    = {rd_sh_q[6:0], 1'b0};
              sdio_oe_d  = 1'b1;
            end else begin
              sdio_out_d = 1'b0;
              sdio_oe_d  = 1'b0;
            end
          end
          if (rise_q) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              byte_end  = 1'b1;
              rd_sh_d   = rd_byte;
            end
          end
        end
      endcase

      if (byte_end) begin
        addr_d = addr_q - 13'd1;
        if (!done_q && wcnt_q != 2'd3) begin
          if (byte_cnt_q == wcnt_q) done_d = 1'b1;
          else                      byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      // csb synchronizer resets low so a csb already low at release is not seen as a fall.
      sclk_sync_q <= '0;
      csb_sync_q  <= '0;
      sdio_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      csb_prev_q  <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      instr_sh_q  <= '0;
      dat_sh_q    <= '0;
      rd_sh_q     <= '0;
      wcnt_q      <= '0;
      byte_cnt_q  <= '0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      sdio_out_q  <= 1'b0;
      sdio_oe_q   <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      csb_sync_q  <= csb_sync_d;
      sdio_sync_q <= sdio_sync_d;
      sclk_prev_q <= sclk_prev_d;
      csb_prev_q  <= csb_prev_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      instr_sh_q  <= instr_sh_d;
      dat_sh_q    <= dat_sh_d;
      rd_sh_q     <= rd_sh_d;
      wcnt_q      <= wcnt_d;
      byte_cnt_q  <= byte_cnt_d;
      done_q      <= done_d;
      addr_q      <= addr_d;
      sdio_out_q  <= sdio_out_d;
      sdio_oe_q   <= sdio_oe_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign spi.sdio_out = sdio_out_q;
  assign spi.sdio_oe  = sdio_oe_q;
  assign wr_stb       = wr_stb_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign busy         = (state_q != ST_IDLE);
endmodule

// File: doc/spi_register_slave.md
# spi_register_slave

Responder end of the 3-wire SPI configuration link driven by `spi_controller`. It decodes the controller's instruction/data stream on `sclk`/`csb`/`sdio`, services writes and reads against an internal byte-wide register file, and drives read data back on the shared `sdio` line. It is used as the on-board device model in the controller bench and as the configuration target inside DAQ firmware blocks. It oversamples the SPI pins in the `sys_clk` domain; there is no second clock.

## Interface
- `DEPTH_LOG2`, default 4: register file holds 2^DEPTH_LOG2 bytes at addresses 0 .. 2^DEPTH_LOG2-1.
- `sys_clk`  input  1: system clock; all logic is on its rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `sclk`  input  1: SPI clock from the controller; idles low.
- `csb`  input  1: chip select, active low.
- `sdio_in`  input  1: sampled `sdio` pad value.
- `sdio_out`  output  1: read data to the `sdio` pad.
- `sdio_oe`  output  1: pad output enable; 1 means this block drives `sdio`.
- `wr_stb`  output  1: one-cycle pulse per completed write byte.
- `wr_addr`  output  13: address of the byte reported by `wr_stb`.
- `wr_data`  output  8: data of the byte reported by `wr_stb`.
- `busy`  output  1: high while a transaction is in progress, i.e. state is not IDLE.

## Operation
- `sclk`, `csb` and `sdio_in` pass through 2-flop synchronizers. A registered previous value gives rise/fall detect on synced `sclk`.
- Frame format, MSB first:
  - 16-bit instruction: bit15 R/W (1 = read); bits14:13 W1:W0, byte count 1/2/3, with 3 meaning streaming; bits12:0 start address.
  - Then data bytes, MSB first.
- Bits are sampled on `sclk` rise. Read data changes on `sclk` fall.
- State machine:
  - IDLE: leave on synced `csb` falling to INSTR, clearing the bit counter.
  - INSTR: after 16 rises, go to WDATA or RDATA.
  - WDATA / RDATA: byte loop.
  - Any state returns to IDLE within 1 cycle of synced `csb` high.
- After each byte, the address decrements by 1. It is 13-bit and wraps 0x0000 -> 0x1FFF.
- Byte count: W1:W0 = 0..2 gives W1:W0+1 bytes. Bytes past the count are ignored (not written, `sdio_oe` low). W1:W0 = 3 continues until `csb` rises.
- Write: on the 8th data rise, update the register if addr < 2^DEPTH_LOG2. `wr_stb`/`wr_addr`/`wr_data` are reported for every byte, including out-of-range addresses.
- Read: at each byte start, load the shifter from the register, or 0x00 if out of range. `sdio_oe`=1 from the `sclk` fall following instruction bit 0 until `csb` rises or the byte count is exhausted.
- `csb` high mid-byte: discard the partial byte (no write, no strobe); `sdio_oe` drops.
- Reset:
  - Register file cleared to 0x00.
  - `sdio_out`, `sdio_oe`, `wr_stb`, `wr_addr`, `wr_data`, `busy` all 0; state IDLE.
  - Reset mid-transaction aborts identically. The block resumes only on the next `csb` fall.

## Timing
- Requirement: `sclk` high and low times ≥ 4 `sys_clk` periods. `csb` setup to first `sclk` rise ≥ 4 periods.
- Pin-to-action latency is 3 `sys_clk` cycles: 2 sync + 1 edge register.
- `wr_stb` asserts 1 cycle after the 8th data rise is detected, so 4 cycles after the pad edge. It lasts exactly 1 cycle. `wr_addr`/`wr_data` are valid in that cycle and held until the next strobe.
- `sdio_out` is updated 1 cycle after the synced `sclk` fall is detected, so 4 cycles after the pad edge.
- `busy` rises 3 cycles after `csb` falls and falls 3 cycles after `csb` rises.
- `sdio_oe` deasserts 3 cycles after `csb` rises.
- Simultaneous `csb` rise and `sclk` rise in the same synced cycle: abort wins; the bit is not taken.

## Test plan
- Write 0x005 = 0xA5 (instr 0x0005), then read 0x005 (instr 0x8005) -> one `wr_stb`, addr 0x005, data 0xA5. Read returns 0xA5 on `sdio_out` with `sdio_oe`=1 for exactly 8 `sclk` cycles.
- Streaming write (W1:W0=3) at 0x00A with bytes 0x11, 0x22, 0x33 -> strobes at 0x00A/0x11, 0x009/0x22, 0x008/0x33. A streaming readback returns the same bytes.
- Two-byte write (W1:W0=1) at 0x000 with 3 bytes sent -> strobes at 0x000 and 0x1FFF (wrap, out of range, no storage). Third byte ignored; register 0 = first byte.
- Read 0x100 (out of range) -> `sdio_out` shifts 0x00. Write 0x100 = 0xFF -> strobe reported, register file unchanged.
- `csb` raised after 5 data bits of a write to 0x003 -> no `wr_stb`. Register 0x003 still 0x00. `busy`/`sdio_oe` low within 3 cycles.
- `reset_n` pulsed low during a read's 4th data bit -> all outputs 0 immediately. A following full write/read transaction completes correctly.
